regfile_write_queue_decoder: RTL and testbench

//  Parametrised successor to the register-file write-select decoder. Buffers register write

---
 rtl/regfile_write_queue_decoder.sv | 86 ++++++++
 tb/tb_regfile_write_queue_decoder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_queue_decoder.sv
// Register-file write queue: buffers (select, data) write requests in a small FIFO and
// drives one-hot write enables into the register array, plus a per-register pending mask.
module regfile_write_queue_decoder #(
  parameter int SEL_WIDTH   = 5,
  parameter int DATA_WIDTH  = 64,
  parameter int DEPTH       = 4,
  parameter int ZERO_REG_RO = 1,
  localparam int NUM_REGS   = 2 ** SEL_WIDTH,
  localparam int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_WIDTH-1:0]  in_sel,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [SEL_WIDTH-1:0]  out_sel,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [NUM_REGS-1:0]   out_wen,
  output logic [NUM_REGS-1:0]   pending,
  output logic [CNT_W-1:0]      count
);

  localparam int PTR_W     = $clog2(DEPTH);
  localparam bit DROP_ZERO = (ZERO_REG_RO != 0);

  logic [SEL_WIDTH-1:0]  sel_mem  [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  logic push;
  logic store;
  logic pop;

  // Handshake: a transfer happens on an edge where valid && ready are both high; valid and
  // payload hold until that edge. in_ready ignores out_ready, so a full queue never accepts.
  assign in_ready  = (count != CNT_W'(DEPTH)) && !flush;
  assign push      = in_valid && in_ready;
  assign store     = push && !(DROP_ZERO && (in_sel == '0));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;

  assign out_sel  = sel_mem[rd_ptr];
  assign out_data = data_mem[rd_ptr];
  assign out_wen  = pop ? (NUM_REGS'(1) << out_sel) : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (store && !pop)      count <= count + 1'b1;
      else if (pop && !store) count <= count - 1'b1;
    end
  end

  // Storage carries no reset; occupancy is defined purely by the pointers and count.
  always_ff @(posedge clock) begin
    if (store) begin
      sel_mem[wr_ptr]  <= in_sel;
      data_mem[wr_ptr] <= in_data;
    end
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] offset;
      offset = PTR_W'(i) - rd_ptr;
      if (CNT_W'(offset) < count) pending[sel_mem[i]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_write_queue_decoder.sv
// Directed bench for regfile_write_queue_decoder: reset, single write, backpressure,
// wrap with streaming, zero-register handling and flush behaviour.
module tb_regfile_write_queue_decoder;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_sel;
  logic [63:0] in_data;
  logic        out_ready;
  logic        out_valid;
  logic [4:0]  out_sel;
  logic [63:0] out_data;
  logic [31:0] out_wen;
  logic [31:0] pending;
  logic [2:0]  count;

  // second instance with register 0 writable; shares every input
  logic        z_in_ready;
  logic        z_out_valid;
  logic [4:0]  z_out_sel;
  logic [63:0] z_out_data;
  logic [31:0] z_out_wen;
  logic [31:0] z_pending;
  logic [2:0]  z_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0] exp_q[$];

  regfile_write_queue_decoder #(.SEL_WIDTH(5), .DATA_WIDTH(64), .DEPTH(4), .ZERO_REG_RO(1)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out_ready(out_ready), .out_valid(out_valid), .out_sel(out_sel), .out_data(out_data),
    .out_wen(out_wen), .pending(pending), .count(count)
  );

  regfile_write_queue_decoder #(.SEL_WIDTH(5), .DATA_WIDTH(64), .DEPTH(4), .ZERO_REG_RO(0)) dut_z (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(z_in_ready), .in_sel(in_sel), .in_data(in_data),
    .out_ready(out_ready), .out_valid(z_out_valid), .out_sel(z_out_sel), .out_data(z_out_data),
    .out_wen(z_out_wen), .pending(z_pending), .count(z_count)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] oh(input int s);
    logic [31:0] one;
    one = 32'h1;
    return one << s;
  endfunction

  task automatic idle_inputs();
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_data   = '0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clock);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_checks++; if (pending !== 32'h0) begin n_fail++; $display("FAIL reset_pending got %h exp 0", pending); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock);
      in_valid = 1'b1; in_sel = 5'(i); in_data = 64'(i);
    end
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL pre_reset_count got %0d exp 3", count); end
    // mid-cycle asynchronous reset with a pop requested
    out_ready = 1'b1;
    #2 reset = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid got %b exp 0", out_valid); end
    n_checks++; if (pending !== 32'h0) begin n_fail++; $display("FAIL midreset_pending got %h exp 0", pending); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL midreset_count got %0d exp 0", count); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready got %b exp 1", in_ready); end
    n_checks++; if (out_wen !== 32'h0) begin n_fail++; $display("FAIL midreset_out_wen got %h exp 0", out_wen); end
    @(negedge clock);
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single_write();
    @(negedge clock);
    in_valid = 1'b1; in_sel = 5'd5; in_data = 64'hA5; out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready got %b exp 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass got %b exp 0", out_valid); end
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    n_checks++; if (out_wen !== 32'h20) begin n_fail++; $display("FAIL single_out_wen got %h exp 00000020", out_wen); end
    n_checks++; if (out_data !== 64'hA5) begin n_fail++; $display("FAIL single_out_data got %h exp a5", out_data); end
    n_checks++; if (pending !== 32'h20) begin n_fail++; $display("FAIL single_pending got %h exp 00000020", pending); end
    @(negedge clock);
    #1;
    n_checks++; if (pending !== 32'h0) begin n_fail++; $display("FAIL single_pending_after got %h exp 0", pending); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL single_count_after got %0d exp 0", count); end
    n_checks++; if (out_wen !== 32'h0) begin n_fail++; $display("FAIL single_wen_after got %h exp 0", out_wen); end
    idle_inputs();
  endtask

  task automatic test_full_backpressure();
    logic pushed5;
    logic exp_rdy;
    exp_q.delete();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      in_valid = 1'b1; in_sel = 5'(i); in_data = 64'(16 * i); out_ready = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_fill_in_ready[%0d] got %b exp 1", i, in_ready); end
      exp_q.push_back(5'(i));
    end
    repeat (2) begin
      @(negedge clock);
      in_valid = 1'b1; in_sel = 5'd5; in_data = 64'h55;
      #1;
      n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d exp 4", count); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
      n_checks++; if (pending !== 32'h1E) begin n_fail++; $display("FAIL full_pending got %h exp 0000001e", pending); end
      n_checks++; if (out_wen !== 32'h0) begin n_fail++; $display("FAIL full_wen_stalled got %h exp 0", out_wen); end
    end
    pushed5 = 1'b0;
    for (int c = 0; c < 12 && (exp_q.size() > 0 || !pushed5); c++) begin
      @(negedge clock);
      in_valid = !pushed5; in_sel = 5'd5; in_data = 64'h55; out_ready = 1'b1;
      #1;
      exp_rdy = (exp_q.size() != 4);
      n_checks++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL drain_in_ready[%0d] got %b exp %b", c, in_ready, exp_rdy); end
      n_checks++; if (count !== 3'(exp_q.size())) begin n_fail++; $display("FAIL drain_count[%0d] got %0d exp %0d", c, count, exp_q.size()); end
      if (exp_q.size() > 0) begin
        n_checks++; if (out_sel !== exp_q[0]) begin n_fail++; $display("FAIL drain_out_sel[%0d] got %0d exp %0d", c, out_sel, exp_q[0]); end
        n_checks++; if (out_wen !== oh(int'(exp_q[0]))) begin n_fail++; $display("FAIL drain_out_wen[%0d] got %h exp %h", c, out_wen, oh(int'(exp_q[0]))); end
        void'(exp_q.pop_front());
      end
      if (in_valid && exp_rdy) begin
        exp_q.push_back(5'd5);
        pushed5 = 1'b1;
      end
    end
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL drain_count_final got %0d exp 0", count); end
    idle_inputs();
  endtask

  task automatic test_wrap_stream();
    logic [63:0] exp_data[$];
    exp_q.delete();
    for (int c = 0; c <= 12; c++) begin
      @(negedge clock);
      in_valid = (c < 12); in_sel = 5'(c + 10); in_data = 64'(c * 7 + 3); out_ready = 1'b1;
      #1;
      n_checks++; if (count !== 3'(exp_q.size())) begin n_fail++; $display("FAIL wrap_count[%0d] got %0d exp %0d", c, count, exp_q.size()); end
      if (exp_q.size() > 0) begin
        n_checks++; if (out_sel !== exp_q[0]) begin n_fail++; $display("FAIL wrap_out_sel[%0d] got %0d exp %0d", c, out_sel, exp_q[0]); end
        n_checks++; if (out_data !== exp_data[0]) begin n_fail++; $display("FAIL wrap_out_data[%0d] got %h exp %h", c, out_data, exp_data[0]); end
        void'(exp_q.pop_front());
        void'(exp_data.pop_front());
      end
      if (in_valid) begin
        exp_q.push_back(in_sel);
        exp_data.push_back(in_data);
      end
    end
    @(negedge clock);
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL wrap_count_final got %0d exp 0", count); end
    idle_inputs();
  endtask

  task automatic test_zero_register();
    @(negedge clock);
    in_valid = 1'b1; in_sel = 5'd0; in_data = 64'hDEAD; out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL zero_in_ready got %b exp 1", in_ready); end
    @(negedge clock);
    in_valid = 1'b1; in_sel = 5'd3; in_data = 64'h33;
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL zero_count got %0d exp 0", count); end
    n_checks++; if (out_wen !== 32'h0) begin n_fail++; $display("FAIL zero_out_wen got %h exp 0", out_wen); end
    n_checks++; if (z_out_wen !== 32'h1) begin n_fail++; $display("FAIL zero_rw_out_wen got %h exp 00000001", z_out_wen); end
    n_checks++; if (z_out_data !== 64'hDEAD) begin n_fail++; $display("FAIL zero_rw_out_data got %h exp dead", z_out_data); end
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    n_checks++; if (out_wen !== 32'h8) begin n_fail++; $display("FAIL zero_next_out_wen got %h exp 00000008", out_wen); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL zero_next_count got %0d exp 1", count); end
    n_checks++; if (z_out_sel !== 5'd3) begin n_fail++; $display("FAIL zero_rw_next_sel got %0d exp 3", z_out_sel); end
    @(negedge clock);
    #1;
    n_checks++; if (z_count !== 3'd0) begin n_fail++; $display("FAIL zero_rw_count_final got %0d exp 0", z_count); end
    idle_inputs();
  endtask

  task automatic test_flush_duplicates();
    int wen7 = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      in_valid = 1'b1; in_sel = (i < 2) ? 5'd7 : 5'd9; in_data = 64'(70 + i); out_ready = 1'b0;
    end
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    n_checks++; if (pending !== 32'h280) begin n_fail++; $display("FAIL flush_pending_q got %h exp 00000280", pending); end
    @(negedge clock);
    out_ready = 1'b1;
    #1;
    if (out_wen[7]) wen7++;
    n_checks++; if (out_data !== 64'd70) begin n_fail++; $display("FAIL flush_pop_data got %0d exp 70", out_data); end
    @(negedge clock);
    out_ready = 1'b0;
    #1;
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL flush_count_pre got %0d exp 2", count); end
    n_checks++; if (pending !== 32'h280) begin n_fail++; $display("FAIL flush_pending_dup got %h exp 00000280", pending); end
    @(negedge clock);
    flush = 1'b1; in_valid = 1'b1; in_sel = 5'd11; in_data = 64'hBB;
    #1;
    if (out_wen[7]) wen7++;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
    @(negedge clock);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count_post got %0d exp 0", count); end
    n_checks++; if (pending !== 32'h0) begin n_fail++; $display("FAIL flush_pending_post got %h exp 0", pending); end
    n_checks++; if (wen7 !== 1) begin n_fail++; $display("FAIL flush_wen7_writes got %0d exp 1", wen7); end
    idle_inputs();
  endtask

  task automatic test_flush_with_pop();
    @(negedge clock);
    in_valid = 1'b1; in_sel = 5'd2; in_data = 64'h22; out_ready = 1'b0;
    @(negedge clock);
    flush = 1'b1; in_valid = 1'b1; in_sel = 5'd6; out_ready = 1'b1;
    #1;
    n_checks++; if (out_wen !== 32'h4) begin n_fail++; $display("FAIL flushpop_out_wen got %h exp 00000004", out_wen); end
    @(negedge clock);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flushpop_out_valid got %b exp 0", out_valid); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL flushpop_count got %0d exp 0", count); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_full_backpressure();
    test_wrap_stream();
    test_zero_register();
    test_flush_duplicates();
    test_flush_with_pop();
    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
